// File: rtl/axi_rd_buf_pkg.sv
// Shared constants and helpers for the AXI read-data buffer.
// Store-and-forward mode is enabled by defining AXI_RD_BUF_STORE_FWD_EN.
package axi_rd_buf_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Width of a counter that must hold every value from 0 up to n inclusive.
  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/axi_rd_buf_mem.sv
// Beat storage: synchronous write port, asynchronous read port, no reset.
// Part of axi_rd_data_buf (store-and-forward via AXI_RD_BUF_STORE_FWD_EN).
module axi_rd_buf_mem #(
  parameter int WIDTH      = 48,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_rd_data_buf.sv
// First-word-fall-through AXI R-channel buffer with occupancy and burst counts.
// Define AXI_RD_BUF_STORE_FWD_EN to hold each burst until it is fully buffered.
module axi_rd_data_buf
  import axi_rd_buf_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ID_MAX_WIDTH = 12,
  parameter int DEPTH        = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ID_MAX_WIDTH-1:0]    s_rid,
  input  logic [DATA_WIDTH-1:0]      s_rdata,
  input  logic [1:0]                 s_rresp,
  input  logic                       s_rlast,
  input  logic                       s_ruser,
  input  logic                       s_rvalid,
  output logic                       s_rready,
  output logic [ID_MAX_WIDTH-1:0]    m_rid,
  output logic [DATA_WIDTH-1:0]      m_rdata,
  output logic [1:0]                 m_rresp,
  output logic                       m_rlast,
  output logic                       m_ruser,
  output logic                       m_rvalid,
  input  logic                       m_rready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [$clog2(DEPTH+1)-1:0] burst_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = clog2p1(DEPTH);
  localparam int EW = ID_MAX_WIDTH + DATA_WIDTH + 4;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           level_q, level_d, burst_cnt_q, burst_cnt_d;
  logic [EW-1:0]           wr_entry, head_entry;
  logic [ID_MAX_WIDTH-1:0] head_rid;
  logic [DATA_WIDTH-1:0]   head_rdata;
  logic [1:0]              head_rresp;
  logic                    head_rlast, head_ruser;
  logic                    push, pop, rel_en;

  assign wr_entry = {s_rid, s_rdata, s_rresp, s_rlast, s_ruser};
  assign {head_rid, head_rdata, head_rresp, head_rlast, head_ruser} = head_entry;

  axi_rd_buf_mem #(
    .WIDTH      (EW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (head_entry)
  );

  // No pass-through when full: readiness depends only on registered level.
  assign s_rready = !rst && (level_q != FULL_LEVEL);
  assign m_rvalid = (level_q != '0) && rel_en;
  assign push     = s_rvalid && s_rready;
  assign pop      = m_rvalid && m_rready;

  assign m_rid     = m_rvalid ? head_rid   : '0;
  assign m_rdata   = m_rvalid ? head_rdata : '0;
  assign m_rresp   = m_rvalid ? head_rresp : '0;
  assign m_rlast   = m_rvalid ? head_rlast : 1'b0;
  assign m_ruser   = m_rvalid ? head_ruser : 1'b0;
  assign level     = level_q;
  assign burst_cnt = burst_cnt_q;

`ifdef AXI_RD_BUF_STORE_FWD_EN
  logic draining_q, draining_d;

  // Full-level release keeps bursts longer than the buffer from deadlocking.
  assign rel_en = (burst_cnt_q != '0) || (level_q == FULL_LEVEL) || draining_q;

  always_comb begin
    draining_d = draining_q;
    if (m_rvalid) begin
      draining_d = 1'b1;
    end
    if (pop && head_rlast) begin
      draining_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      draining_q <= 1'b0;
    end else begin
      draining_q <= draining_d;
    end
  end
`else
  assign rel_en = 1'b1;
`endif

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    burst_cnt_d = burst_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + CW'(1);
      2'b01:   level_d = level_q - CW'(1);
      default: level_d = level_q;
    endcase
    case ({push && s_rlast, pop && head_rlast})
      2'b10:   burst_cnt_d = burst_cnt_q + CW'(1);
      2'b01:   burst_cnt_d = burst_cnt_q - CW'(1);
      default: burst_cnt_d = burst_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_data_buf.sv
// Self-checking bench for axi_rd_data_buf: vector table plus multi-cycle sequences.
// Store-and-forward sequences run when AXI_RD_BUF_STORE_FWD_EN is defined.
`timescale 1ns/1ps
module tb_axi_rd_data_buf;
  import axi_rd_buf_pkg::*;

  localparam int DW    = 32;
  localparam int IW    = 12;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int EW    = IW + DW + 4;

  typedef logic [EW-1:0] ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] s_rid = '0;
  logic [DW-1:0] s_rdata = '0;
  logic [1:0]    s_rresp = '0;
  logic          s_rlast = 1'b0;
  logic          s_ruser = 1'b0;
  logic          s_rvalid = 1'b0;
  logic          s_rready;
  logic [IW-1:0] m_rid;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic          m_ruser;
  logic          m_rvalid;
  logic          m_rready = 1'b0;
  logic [CW-1:0] level;
  logic [CW-1:0] burst_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_rd_data_buf #(
    .DATA_WIDTH   (DW),
    .ID_MAX_WIDTH (IW),
    .DEPTH        (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_rid     (s_rid),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rlast   (s_rlast),
    .s_ruser   (s_ruser),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .m_rid     (m_rid),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .m_ruser   (m_ruser),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .level     (level),
    .burst_cnt (burst_cnt)
  );

  typedef struct {
    logic          rst;
    logic          s_rvalid;
    logic [IW-1:0] s_rid;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rlast;
    logic          m_rready;
    logic          e_s_rready;
    logic          e_m_rvalid;
    logic [IW-1:0] e_m_rid;
    logic [DW-1:0] e_m_rdata;
    logic [1:0]    e_m_rresp;
    logic          e_m_rlast;
    logic [CW-1:0] e_level;
    logic [CW-1:0] e_burst;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic sv, input logic [IW-1:0] id,
                              input logic [DW-1:0] d, input logic [1:0] rs, input logic sl,
                              input logic mr, input logic es, input logic em,
                              input logic [IW-1:0] eid, input logic [DW-1:0] ed,
                              input logic [1:0] ers, input logic el, input int lvl, input int bc);
    vec_t v;
    v.rst = r;        v.s_rvalid = sv;  v.s_rid = id;      v.s_rdata = d;
    v.s_rresp = rs;   v.s_rlast = sl;   v.m_rready = mr;   v.e_s_rready = es;
    v.e_m_rvalid = em; v.e_m_rid = eid; v.e_m_rdata = ed;  v.e_m_rresp = ers;
    v.e_m_rlast = el; v.e_level = CW'(lvl); v.e_burst = CW'(bc);
    return v;
  endfunction

  function automatic ent_t beat_ent(input int i);
    logic [IW-1:0] id;
    logic [DW-1:0] d;
    logic [1:0]    rs;
    id = IW'(i + 12'h40);
    d  = DW'(i);
    rs = 2'(i % 4);
    return {id, d, rs, (i % 4) == 3 || i == 99, id[0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveBeat(input logic [IW-1:0] id, input logic [DW-1:0] d,
                           input logic [1:0] rs, input logic l);
    s_rvalid = 1'b1;
    s_rid    = id;
    s_rdata  = d;
    s_rresp  = rs;
    s_rlast  = l;
    s_ruser  = id[0];
  endtask

  task automatic setIdle();
    s_rvalid = 1'b0;
    s_rid    = '0;
    s_rdata  = '0;
    s_rresp  = '0;
    s_rlast  = 1'b0;
    s_ruser  = 1'b0;
    m_rready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst      = v.rst;
    s_rvalid = v.s_rvalid;
    s_rid    = v.s_rid;
    s_rdata  = v.s_rdata;
    s_rresp  = v.s_rresp;
    s_rlast  = v.s_rlast;
    s_ruser  = v.s_rid[0];
    m_rready = v.m_rready;
  endtask

  task automatic checkOutput(input vec_t v, input int i);
    check($sformatf("v%0d_s_rready", i), 64'(s_rready), 64'(v.e_s_rready));
    check($sformatf("v%0d_m_rvalid", i), 64'(m_rvalid), 64'(v.e_m_rvalid));
    check($sformatf("v%0d_m_rid", i), 64'(m_rid), 64'(v.e_m_rid));
    check($sformatf("v%0d_m_rdata", i), 64'(m_rdata), 64'(v.e_m_rdata));
    check($sformatf("v%0d_m_rresp", i), 64'(m_rresp), 64'(v.e_m_rresp));
    check($sformatf("v%0d_m_rlast", i), 64'(m_rlast), 64'(v.e_m_rlast));
    check($sformatf("v%0d_m_ruser", i), 64'(m_ruser), 64'(v.e_m_rvalid & v.e_m_rid[0]));
    check($sformatf("v%0d_level", i), 64'(level), 64'(v.e_level));
    check($sformatf("v%0d_burst_cnt", i), 64'(burst_cnt), 64'(v.e_burst));
  endtask

  vec_t vecs[14];
  ent_t sb[$];

  initial begin
    ent_t cur, prev_ent, exp_ent;
    logic prev_hold;
    int   sent, got, cyc;

    vecs[0]  = mk(0, 1, 12'h3,  32'hA5A5_0001, 2'd0, 1, 0,  1, 0, 12'h0,  32'h0,          2'd0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 12'h0,  32'h0,         2'd0, 0, 1,  1, 1, 12'h3,  32'hA5A5_0001,  2'd0, 1, 1, 1);
    vecs[2]  = mk(0, 0, 12'h0,  32'h0,         2'd0, 0, 0,  1, 0, 12'h0,  32'h0,          2'd0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 12'h10, 32'h10,        2'd0, 1, 0,  1, 0, 12'h0,  32'h0,          2'd0, 0, 0, 0);
    vecs[4]  = mk(0, 1, 12'h11, 32'h11,        2'd2, 1, 0,  1, 1, 12'h10, 32'h10,         2'd0, 1, 1, 1);
    vecs[5]  = mk(0, 1, 12'h12, 32'h12,        2'd0, 1, 0,  1, 1, 12'h10, 32'h10,         2'd0, 1, 2, 2);
    vecs[6]  = mk(0, 1, 12'h13, 32'h13,        2'd1, 1, 0,  1, 1, 12'h10, 32'h10,         2'd0, 1, 3, 3);
    vecs[7]  = mk(0, 1, 12'h14, 32'h14,        2'd3, 1, 1,  1, 1, 12'h10, 32'h10,         2'd0, 1, 4, 4);
    vecs[8]  = mk(0, 1, 12'h15, 32'h15,        2'd0, 1, 1,  1, 1, 12'h11, 32'h11,         2'd2, 1, 4, 4);
    vecs[9]  = mk(0, 0, 12'h0,  32'h0,         2'd0, 0, 1,  1, 1, 12'h12, 32'h12,         2'd0, 1, 4, 4);
    vecs[10] = mk(0, 0, 12'h0,  32'h0,         2'd0, 0, 1,  1, 1, 12'h13, 32'h13,         2'd1, 1, 3, 3);
    vecs[11] = mk(0, 0, 12'h0,  32'h0,         2'd0, 0, 1,  1, 1, 12'h14, 32'h14,         2'd3, 1, 2, 2);
    vecs[12] = mk(0, 0, 12'h0,  32'h0,         2'd0, 0, 1,  1, 1, 12'h15, 32'h15,         2'd0, 1, 1, 1);
    vecs[13] = mk(0, 0, 12'h0,  32'h0,         2'd0, 0, 0,  1, 0, 12'h0,  32'h0,          2'd0, 0, 0, 0);

    // Reset state
    setIdle();
    rst = 1'b1;
    tick();
    tick();
    check("rst_s_rready", 64'(s_rready), 64'd0);
    check("rst_m_rvalid", 64'(m_rvalid), 64'd0);
    check("rst_m_rdata", 64'(m_rdata), 64'd0);
    check("rst_m_rid", 64'(m_rid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_burst_cnt", 64'(burst_cnt), 64'd0);

`ifndef AXI_RD_BUF_STORE_FWD_EN
    $display("[TB] cut-through vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
      tick();
    end
`else
    rst = 1'b0;
    $display("[TB] store-and-forward three-beat burst");
    for (int k = 0; k < 3; k++) begin
      driveBeat(IW'(k), 32'h500 + DW'(k), 2'd0, k == 2);
      #1;
      check("sf3_held", 64'(m_rvalid), 64'd0);
      tick();
    end
    setIdle();
    m_rready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      check("sf3_valid", 64'(m_rvalid), 64'd1);
      check("sf3_data", 64'(m_rdata), 64'h500 + 64'(j));
      tick();
    end
    #1;
    check("sf3_empty_valid", 64'(m_rvalid), 64'd0);
    check("sf3_empty_burst", 64'(burst_cnt), 64'd0);
    tick();

    $display("[TB] store-and-forward 12-beat burst");
    setIdle();
    for (int k = 0; k < 8; k++) begin
      driveBeat(IW'(k), 32'h600 + DW'(k), 2'd0, 1'b0);
      #1;
      check("sf12_held", 64'(m_rvalid), 64'd0);
      tick();
    end
    driveBeat(IW'(8), 32'h608, 2'd0, 1'b0);
    #1;
    check("sf12_full_level", 64'(level), 64'd8);
    check("sf12_full_valid", 64'(m_rvalid), 64'd1);
    check("sf12_full_rdy", 64'(s_rready), 64'd0);
    m_rready = 1'b1;
    sent = 8;
    for (int j = 0; j < 12; j++) begin
      if (sent < 12) driveBeat(IW'(sent), 32'h600 + DW'(sent), 2'd0, sent == 11);
      else s_rvalid = 1'b0;
      #1;
      check("sf12_valid", 64'(m_rvalid), 64'd1);
      check("sf12_data", 64'(m_rdata), 64'h600 + 64'(j));
      if (s_rvalid && s_rready) sent++;
      tick();
    end
    setIdle();
    #1;
    check("sf12_sent", 64'(sent), 64'd12);
    check("sf12_done_valid", 64'(m_rvalid), 64'd0);
    check("sf12_done_level", 64'(level), 64'd0);
    tick();
`endif

    $display("[TB] fill and stall");
    rst = 1'b0;
    setIdle();
    for (int k = 0; k < 8; k++) begin
      driveBeat(IW'(k), 32'h100 + DW'(k), 2'd0, 1'b0);
      #1;
      check("fill_rdy", 64'(s_rready), 64'd1);
      tick();
    end
    driveBeat(IW'(8), 32'h108, 2'd0, 1'b1);
    #1;
    check("full_rdy", 64'(s_rready), 64'd0);
    check("full_level", 64'(level), 64'd8);
    check("full_valid", 64'(m_rvalid), 64'd1);
    check("full_head", 64'(m_rdata), 64'h100);
    tick();
    check("stall_rdy", 64'(s_rready), 64'd0);
    m_rready = 1'b1;
    #1;
    check("full_pop_rdy", 64'(s_rready), 64'd0);
    tick();
    m_rready = 1'b0;
    #1;
    check("refill_rdy", 64'(s_rready), 64'd1);
    check("refill_level", 64'(level), 64'd7);
    tick();
    s_rvalid = 1'b0;
    #1;
    check("refull_level", 64'(level), 64'd8);
    check("refull_burst", 64'(burst_cnt), 64'd1);
    m_rready = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      #1;
      check("drain_valid", 64'(m_rvalid), 64'd1);
      check("drain_data", 64'(m_rdata), 64'h100 + 64'(j));
      tick();
    end
    setIdle();
    #1;
    check("drain_level", 64'(level), 64'd0);
    check("drain_burst", 64'(burst_cnt), 64'd0);
    tick();

    $display("[TB] 100-beat stream with random backpressure");
    sent = 0;
    got = 0;
    cyc = 0;
    prev_hold = 1'b0;
    prev_ent = '0;
    while (got < 100 && cyc < 3000) begin
      if (sent < 100) begin
        cur = beat_ent(sent);
        driveBeat(cur[EW-1 -: IW], cur[DW+3:4], cur[3:2], cur[1]);
      end else begin
        s_rvalid = 1'b0;
      end
      m_rready = 1'($urandom_range(0, 1));
      #1;
      cur = {m_rid, m_rdata, m_rresp, m_rlast, m_ruser};
      if (prev_hold) begin
        check("hold_valid", 64'(m_rvalid), 64'd1);
        check("hold_payload", 64'(cur), 64'(prev_ent));
      end
      if (m_rvalid && m_rready) begin
        exp_ent = (sb.size() != 0) ? sb.pop_front() : '1;
        check("stream_beat", 64'(cur), 64'(exp_ent));
        got++;
      end
      if (s_rvalid && s_rready) begin
        sb.push_back(beat_ent(sent));
        sent++;
      end
      prev_hold = m_rvalid && !m_rready;
      prev_ent = cur;
      tick();
      cyc++;
    end
    check("stream_count", 64'(got), 64'd100);
    setIdle();
    #1;
    check("stream_level", 64'(level), 64'd0);
    tick();

    $display("[TB] reset mid-burst");
    for (int k = 0; k < 5; k++) begin
      driveBeat(IW'(k), 32'h200 + DW'(k), 2'd0, 1'b0);
      tick();
    end
    s_rvalid = 1'b0;
    #1;
    check("pre_rst_level", 64'(level), 64'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_rdy", 64'(s_rready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_level", 64'(level), 64'd0);
    check("post_rst_burst", 64'(burst_cnt), 64'd0);
    check("post_rst_valid", 64'(m_rvalid), 64'd0);
    check("post_rst_data", 64'(m_rdata), 64'd0);
    check("post_rst_rid", 64'(m_rid), 64'd0);
    check("post_rst_rdy", 64'(s_rready), 64'd1);
    driveBeat(12'h30, 32'h300, 2'd0, 1'b1);
    tick();
    s_rvalid = 1'b0;
    m_rready = 1'b1;
    #1;
    check("post_rst_first_valid", 64'(m_rvalid), 64'd1);
    check("post_rst_first_data", 64'(m_rdata), 64'h300);
    check("post_rst_first_rid", 64'(m_rid), 64'h30);
    tick();
    setIdle();
    #1;
    check("post_rst_empty", 64'(m_rvalid), 64'd0);
    check("post_rst_empty_level", 64'(level), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
